// File: rtl/aref_iseq_scheduler.sv
// Arbitrates the DRAM command path between host instruction sequences, periodic
// reads and auto-refresh, tracking the refresh interval and postponed refreshes.
module aref_iseq_scheduler #(
    parameter int INTERVAL_W = 28,
    parameter int PEND_MAX   = 8,
    parameter int PEND_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aref_set_interval,
    input  logic [INTERVAL_W-1:0] aref_interval,
    input  logic                  aref_set_trfc,
    input  logic [INTERVAL_W-1:0] aref_trfc,
    input  logic                  host_iseq_req,
    output logic                  host_iseq_ack,
    output logic                  process_iseq,
    input  logic                  dispatcher_busy,
    input  logic                  pr_req,
    input  logic                  pr_rd_ack,
    output logic                  periodic_read_lock,
    output logic                  ref_issue,
    output logic                  ref_busy,
    output logic [PEND_W-1:0]     aref_pending,
    output logic                  aref_overflow
);

    typedef enum logic [1:0] {IDLE, ISEQ, PR, REF} state_t;

    state_t                  state_q, state_d;
    logic [INTERVAL_W-1:0]   interval_q, interval_d;
    logic [INTERVAL_W-1:0]   trfc_q, trfc_d;
    logic [INTERVAL_W-1:0]   cnt_q, cnt_d;
    logic [INTERVAL_W-1:0]   trfc_cnt_q, trfc_cnt_d;
    logic [PEND_W-1:0]       pend_q, pend_d;
    logic                    ovf_q, ovf_d;
    logic                    seen_busy_q, seen_busy_d;
    logic                    iseq_second_q, iseq_second_d;
    logic                    ack_q, ack_d;
    logic                    proc_q, proc_d;
    logic                    lock_q, lock_d;
    logic                    issue_q, issue_d;
    logic                    busy_q, busy_d;
    logic                    at_wrap;
    logic                    tick;
    logic                    urgent;

    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    assign at_wrap = (cnt_q == interval_q - INTERVAL_W'(1));
    // A reload in the same cycle restarts the interval, so it suppresses the tick.
    assign tick    = (interval_q != '0) && at_wrap && !aref_set_interval;
    assign urgent  = (pend_q == PEND_FULL);

    always_comb begin
        interval_d = aref_set_interval ? aref_interval : interval_q;
        trfc_d     = aref_set_trfc ? aref_trfc : trfc_q;
        cnt_d      = cnt_q;
        if (aref_set_interval || interval_q == '0 || at_wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + INTERVAL_W'(1);
        end

        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (aref_set_interval && aref_interval == '0) begin
            pend_d = '0;
        end else if (tick && !issue_q) begin
            if (urgent) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!tick && issue_q && pend_q != '0) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        seen_busy_d   = 1'b0;
        iseq_second_d = 1'b0;
        trfc_cnt_d    = trfc_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (urgent) begin
                    state_d = REF;
                end else if (pr_req) begin
                    state_d = PR;
                end else if (host_iseq_req) begin
                    state_d = ISEQ;
                end else if (pend_q != '0) begin
                    state_d = REF;
                end
                trfc_cnt_d = (trfc_q == '0) ? INTERVAL_W'(1) : trfc_q;
            end
            ISEQ: begin
                seen_busy_d   = seen_busy_q | dispatcher_busy;
                iseq_second_d = 1'b1;
                // An empty sequence never raises busy; give up after two cycles.
                if (!dispatcher_busy && (seen_busy_q || iseq_second_q)) begin
                    state_d = IDLE;
                end
            end
            PR: begin
                if (pr_rd_ack) begin
                    state_d = IDLE;
                end
            end
            REF: begin
                if (trfc_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    trfc_cnt_d = trfc_cnt_q - INTERVAL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        proc_d  = (state_q == IDLE) && (state_d == ISEQ);
        ack_d   = proc_d;
        lock_d  = (state_d == PR);
        issue_d = (state_q == IDLE) && (state_d == REF);
        busy_d  = (state_d == REF);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            interval_q    <= '0;
            trfc_q        <= '0;
            cnt_q         <= '0;
            trfc_cnt_q    <= '0;
            pend_q        <= '0;
            ovf_q         <= 1'b0;
            seen_busy_q   <= 1'b0;
            iseq_second_q <= 1'b0;
            ack_q         <= 1'b0;
            proc_q        <= 1'b0;
            lock_q        <= 1'b0;
            issue_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            interval_q    <= interval_d;
            trfc_q        <= trfc_d;
            cnt_q         <= cnt_d;
            trfc_cnt_q    <= trfc_cnt_d;
            pend_q        <= pend_d;
            ovf_q         <= ovf_d;
            seen_busy_q   <= seen_busy_d;
            iseq_second_q <= iseq_second_d;
            ack_q         <= ack_d;
            proc_q        <= proc_d;
            lock_q        <= lock_d;
            issue_q       <= issue_d;
            busy_q        <= busy_d;
        end
    end

    assign host_iseq_ack      = ack_q;
    assign process_iseq       = proc_q;
    assign periodic_read_lock = lock_q;
    assign ref_issue          = issue_q;
    assign ref_busy           = busy_q;
    assign aref_pending       = pend_q;
    assign aref_overflow      = ovf_q;

endmodule

// File: tb/tb_aref_iseq_scheduler.sv
// Directed bench for aref_iseq_scheduler: expected grants are queued by the
// stimulus and checked in order by a negedge monitor.
module tb_aref_iseq_scheduler;

    localparam int IW = 28;
    localparam int PW = 4;
    localparam int K_ISEQ = 0;
    localparam int K_PR   = 1;
    localparam int K_REF  = 2;

    typedef struct {
        int kind;
        int pend;
        int blen;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          aref_set_interval = 1'b0;
    logic [IW-1:0] aref_interval = '0;
    logic          aref_set_trfc = 1'b0;
    logic [IW-1:0] aref_trfc = '0;
    logic          host_iseq_req = 1'b0;
    logic          host_iseq_ack;
    logic          process_iseq;
    logic          dispatcher_busy = 1'b0;
    logic          pr_req = 1'b0;
    logic          pr_rd_ack = 1'b0;
    logic          periodic_read_lock;
    logic          ref_issue;
    logic          ref_busy;
    logic [PW-1:0] aref_pending;
    logic          aref_overflow;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   busy_exp = 0;
    logic lock_prev = 1'b0;

    aref_iseq_scheduler #(.INTERVAL_W(IW), .PEND_MAX(8), .PEND_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .aref_set_interval(aref_set_interval),
        .aref_interval(aref_interval),
        .aref_set_trfc(aref_set_trfc),
        .aref_trfc(aref_trfc),
        .host_iseq_req(host_iseq_req),
        .host_iseq_ack(host_iseq_ack),
        .process_iseq(process_iseq),
        .dispatcher_busy(dispatcher_busy),
        .pr_req(pr_req),
        .pr_rd_ack(pr_rd_ack),
        .periodic_read_lock(periodic_read_lock),
        .ref_issue(ref_issue),
        .ref_busy(ref_busy),
        .aref_pending(aref_pending),
        .aref_overflow(aref_overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input int kind, input int pend, input int blen);
        exp_t e;
        e.kind = kind;
        e.pend = pend;
        e.blen = blen;
        sb_q.push_back(e);
    endfunction

    // Monitor: every grant the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (ref_issue) begin
            $display("[%0t] REF issue pending=%0d", $time, aref_pending);
            chk("sb_has_ref", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ref_kind", K_REF, e.kind);
                chk("ref_pending", int'(aref_pending), e.pend);
                busy_exp = e.blen;
            end
        end
        if (process_iseq) begin
            $display("[%0t] ISEQ launch ack=%0b", $time, host_iseq_ack);
            chk("sb_has_iseq", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("iseq_kind", K_ISEQ, e.kind);
                chk("iseq_ack", int'(host_iseq_ack), 1);
            end
        end
        if (periodic_read_lock && !lock_prev) begin
            $display("[%0t] PR lock", $time);
            chk("sb_has_pr", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pr_kind", K_PR, e.kind);
            end
        end
        lock_prev = periodic_read_lock;
        if (ref_busy) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            chk("ref_busy_len", busy_cnt, busy_exp);
            busy_cnt = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_interval(input int v);
        aref_interval = IW'(v);
        aref_set_interval = 1'b1;
        cyc(1);
        aref_set_interval = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            cyc(1);
            n++;
        end
        chk("sb_drained", sb_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pend"}, int'(aref_pending), 0);
        chk({tag, "_busy"}, int'(ref_busy), 0);
        chk({tag, "_issue"}, int'(ref_issue), 0);
        chk({tag, "_lock"}, int'(periodic_read_lock), 0);
        chk({tag, "_proc"}, int'(process_iseq), 0);
        chk({tag, "_ack"}, int'(host_iseq_ack), 0);
    endtask

    initial begin
        // Reset, then idle with auto-refresh disabled.
        #12;
        chk_idle_outputs("reset");
        chk("reset_ovf", int'(aref_overflow), 0);
        cyc(2);
        rst = 1'b1;
        cyc(100);
        chk_idle_outputs("idle100");

        // Interval 10, tRFC 5: three refreshes, each 6 busy cycles.
        aref_trfc = IW'(5);
        aref_set_trfc = 1'b1;
        aref_interval = IW'(10);
        aref_set_interval = 1'b1;
        cyc(1);
        aref_set_trfc = 1'b0;
        aref_set_interval = 1'b0;
        push(K_REF, 1, 6);
        push(K_REF, 1, 6);
        push(K_REF, 1, 6);
        cyc(37);
        set_interval(0);
        chk("t2_pend_end", int'(aref_pending), 0);
        drain();
        cyc(5);

        // Long busy sequence saturates pending; refresh wins once it ends.
        host_iseq_req = 1'b1;
        dispatcher_busy = 1'b1;
        push(K_ISEQ, 0, 0);
        set_interval(10);
        cyc(85);
        chk("t3_pend_sat", int'(aref_pending), 8);
        chk("t3_ovf_before", int'(aref_overflow), 0);
        cyc(12);
        chk("t3_pend_sat2", int'(aref_pending), 8);
        chk("t3_ovf_set", int'(aref_overflow), 1);
        push(K_REF, 8, 6);
        push(K_PR, 0, 0);
        push(K_ISEQ, 0, 0);
        dispatcher_busy = 1'b0;
        pr_req = 1'b1;
        cyc(2);
        set_interval(0);
        chk("t3_pend_cleared", int'(aref_pending), 0);
        cyc(8);
        pr_rd_ack = 1'b1;
        pr_req = 1'b0;
        cyc(1);
        pr_rd_ack = 1'b0;
        chk("t3_lock_drop", int'(periodic_read_lock), 0);
        cyc(1);
        chk("t3_proc", int'(process_iseq), 1);
        host_iseq_req = 1'b0;
        cyc(10);
        drain();
        chk("t3_ovf_sticky", int'(aref_overflow), 1);

        // pending = 2, pr_req and host_iseq_req together: PR, gap, ISEQ, REF, REF.
        host_iseq_req = 1'b1;
        dispatcher_busy = 1'b1;
        push(K_ISEQ, 0, 0);
        set_interval(40);
        host_iseq_req = 1'b0;
        cyc(85);
        chk("t4_pend2", int'(aref_pending), 2);
        push(K_PR, 0, 0);
        push(K_ISEQ, 0, 0);
        push(K_REF, 2, 6);
        push(K_REF, 1, 6);
        pr_req = 1'b1;
        host_iseq_req = 1'b1;
        dispatcher_busy = 1'b0;
        cyc(5);
        chk("t4_lock_held", int'(periodic_read_lock), 1);
        pr_rd_ack = 1'b1;
        pr_req = 1'b0;
        cyc(1);
        pr_rd_ack = 1'b0;
        chk("t4_gap_lock", int'(periodic_read_lock), 0);
        chk("t4_gap_proc", int'(process_iseq), 0);
        cyc(1);
        chk("t4_proc", int'(process_iseq), 1);
        host_iseq_req = 1'b0;
        cyc(20);
        set_interval(0);
        chk("t4_pend_end", int'(aref_pending), 0);
        drain();

        // Tick coincident with ref_issue at pending 3, then interval cleared.
        pr_req = 1'b1;
        push(K_PR, 0, 0);
        push(K_REF, 3, 6);
        set_interval(10);
        cyc(37);
        pr_rd_ack = 1'b1;
        pr_req = 1'b0;
        cyc(1);
        pr_rd_ack = 1'b0;
        cyc(1);
        chk("t5_issue", int'(ref_issue), 1);
        chk("t5_pend_at_issue", int'(aref_pending), 3);
        cyc(1);
        chk("t5_pend_coincident", int'(aref_pending), 3);
        cyc(1);
        set_interval(0);
        chk("t5_pend_zeroed", int'(aref_pending), 0);
        cyc(30);
        chk("t5_pend_quiet", int'(aref_pending), 0);
        drain();

        // Reset during REF with the tRFC counter at 3.
        aref_trfc = IW'(7);
        aref_set_trfc = 1'b1;
        push(K_REF, 1, 4);
        set_interval(4);
        aref_set_trfc = 1'b0;
        cyc(9);
        chk("t6_busy_before", int'(ref_busy), 1);
        chk("t6_pend_before", int'(aref_pending), 1);
        rst = 1'b0;
        #1;
        chk("t6_busy_rst", int'(ref_busy), 0);
        chk("t6_pend_rst", int'(aref_pending), 0);
        chk("t6_ovf_rst", int'(aref_overflow), 0);
        cyc(2);
        rst = 1'b1;
        cyc(30);
        chk_idle_outputs("t6_after");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aref_iseq_scheduler.md
Name: aref_iseq_scheduler

Overview:
Top-level sequencer in front of the instruction-sequence dispatcher. It decides which of three activities owns the DRAM command path at any time: a host instruction sequence, a periodic read, or an auto-refresh. It tracks the refresh interval, counts postponed refreshes, and forces a refresh when the postponement budget is exhausted. It consumes the aref_* configuration strobes and drives process_iseq, periodic_read_lock and a refresh-issue pulse.

Parameters:
INTERVAL_W, 28, width of the interval, tRFC and counter registers.
PEND_MAX, 8, maximum postponed refreshes; reaching it makes refresh urgent.
PEND_W, 4, width of the pending-refresh counter; must hold PEND_MAX.

Ports:
clk  in  1  sole clock.
rst  in  1  reset; asynchronous, active-low.
aref_set_interval  in  1  loads aref_interval.
aref_interval  in  INTERVAL_W  refresh interval in clk cycles; 0 disables auto-refresh.
aref_set_trfc  in  1  loads aref_trfc.
aref_trfc  in  INTERVAL_W  cycles the block stays in REF after issue.
host_iseq_req  in  1  level; a loaded instruction sequence awaits dispatch.
host_iseq_ack  out  1  1-cycle pulse when the sequence is launched.
process_iseq  out  1  1-cycle pulse to the dispatcher.
dispatcher_busy  in  1  dispatcher is executing.
pr_req  in  1  level; periodic read requested.
pr_rd_ack  in  1  periodic read done.
periodic_read_lock  out  1  high while the periodic read owns the path.
ref_issue  out  1  1-cycle pulse to the refresh command generator.
ref_busy  out  1  high throughout REF.
aref_pending  out  PEND_W  postponed refresh count.
aref_overflow  out  1  sticky; a tick arrived while the count was saturated.

Behaviour:
- All outputs are registered. During reset they are 0, the interval and tRFC registers are 0, and the FSM is in IDLE.
- Interval counter: runs only when the interval register is nonzero.
  - At count == interval-1 it wraps to 0 and produces a tick.
  - aref_set_interval reloads the register and clears the counter.
  - Loading 0 also clears aref_pending.
- Pending counter, evaluated each cycle:
  - tick alone: +1.
  - ref_issue alone: -1.
  - tick and ref_issue together: unchanged.
  - tick with pending == PEND_MAX and no issue: stays at PEND_MAX, aref_overflow set. aref_overflow is cleared only by reset.
- urgent = (pending == PEND_MAX).
- FSM states: IDLE, ISEQ, PR, REF.
- IDLE arbitration, fixed priority:
  1. urgent -> REF
  2. pr_req -> PR
  3. host_iseq_req -> ISEQ
  4. pending != 0 -> REF
  5. otherwise stay in IDLE.
- No state is preempted. An urgent refresh waits for the current owner to finish.
- ISEQ:
  - process_iseq and host_iseq_ack are high in the first ISEQ cycle only.
  - A seen_busy flag sets when dispatcher_busy is sampled high.
  - Exit to IDLE when seen_busy is set and dispatcher_busy is low.
  - If busy never rises within 2 cycles of process_iseq (empty sequence), exit after those 2 cycles.
- PR:
  - periodic_read_lock is high from the first PR cycle.
  - On pr_rd_ack, go to IDLE. The lock is low in the following cycle.
- REF:
  - ref_issue is high in the first cycle. ref_busy is high for the entire state.
  - A tRFC down-counter loads max(aref_trfc, 1).
  - Exit to IDLE when it reaches 0, giving max(trfc,1)+1 cycles in REF.
- Configuration strobes are accepted in any state. A new tRFC applies from the next REF entry.
- Minimum one IDLE cycle between consecutive grants.
- Reset mid-operation: the FSM returns to IDLE and all counters clear. The dispatcher is not aborted by this block.

Test Plan:
- Reset then idle: interval = 0, all requests low for 100 cycles -> no ref_issue, aref_pending = 0, all outputs 0.
- Interval = 10, tRFC = 5, no other traffic -> ref_issue every 10 cycles; ref_busy high for 6 cycles; aref_pending toggles 1 -> 0.
- Interval = 10, host_iseq_req held with dispatcher_busy held high for 100 cycles -> aref_pending reaches 8. The next tick sets aref_overflow. After busy drops, REF is entered before any pending host_iseq_req or pr_req.
- pr_req and host_iseq_req asserted in the same cycle, pending = 2 -> PR first (lock until pr_rd_ack), then one IDLE cycle, then ISEQ with a single process_iseq pulse, then REF twice.
- Tick coincident with ref_issue at pending = 3 -> pending stays 3. aref_set_interval = 0 mid-run -> pending = 0, no further ticks.
- rst asserted (low) during REF with the tRFC counter at 3 -> ref_busy = 0 and aref_pending = 0 immediately. After release the FSM sits in IDLE with interval = 0.
